// File: rtl/ram_moc_responder.sv
// Byte-addressable big-endian memory answering the CPU Enable/ReadWrite/OP -> MOC
// 4-phase handshake, with word/half/byte transfers and a fixed wait-state count.
module ram_moc_responder #(
  parameter int DEPTH       = 512,
  parameter int ADDR_W      = 9,
  parameter int WAIT_STATES = 2
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              Enable,
  input  logic              ReadWrite,
  input  logic [ADDR_W-1:0] Address,
  input  logic [31:0]       DataIn,
  input  logic [5:0]        OP,
  output logic [31:0]       DataOut,
  output logic              MOC,
  output logic              Err
);

  localparam logic [5:0] OP_WORD = 6'b001000;
  localparam logic [5:0] OP_HALF = 6'b000010;
  localparam logic [5:0] OP_BYTE = 6'b000001;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_BAD} size_t;

  logic [7:0] Mem [0:DEPTH-1];

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              moc_q, moc_d;
  logic              err_q, err_d;
  logic [31:0]       dout_q, dout_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rw_q, rw_d;
  logic [5:0]        op_q, op_d;
  logic [31:0]       din_q, din_d;

  size_t             size;
  logic              legal;
  logic              mem_we;
  logic [ADDR_W-1:0] a1, a2, a3;
  logic [31:0]       rd_data;

  assign a1 = addr_q + ADDR_W'(1);
  assign a2 = addr_q + ADDR_W'(2);
  assign a3 = addr_q + ADDR_W'(3);

  // NOTE: every signal driven in an always_comb gets a default first so no latch is inferred.
  always_comb begin
    size  = SZ_BAD;
    legal = 1'b0;
    unique case (op_q)
      OP_WORD: begin size = SZ_WORD; legal = (addr_q[1:0] == 2'b00); end
      OP_HALF: begin size = SZ_HALF; legal = ~addr_q[0];             end
      OP_BYTE: begin size = SZ_BYTE; legal = 1'b1;                   end
      default: begin size = SZ_BAD;  legal = 1'b0;                   end
    endcase
  end

  always_comb begin
    rd_data = 32'h0;
    unique case (size)
      SZ_WORD: rd_data = {Mem[addr_q], Mem[a1], Mem[a2], Mem[a3]};
      SZ_HALF: rd_data = {16'h0, Mem[addr_q], Mem[a1]};
      SZ_BYTE: rd_data = {24'h0, Mem[addr_q]};
      default: rd_data = 32'h0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    moc_d   = moc_q;
    err_d   = err_q;
    dout_d  = dout_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    op_d    = op_q;
    din_d   = din_q;
    mem_we  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (Enable) begin
          addr_d  = Address;
          rw_d    = ReadWrite;
          op_d    = OP;
          din_d   = DataIn;
          cnt_d   = 4'(WAIT_STATES);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!Enable) begin
          state_d = S_IDLE;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          moc_d   = 1'b1;
          state_d = S_DONE;
          if (!legal) begin
            err_d  = 1'b1;
            dout_d = 32'h0;
          end else if (rw_q) begin
            dout_d = rd_data;
          end else begin
            mem_we = 1'b1;
          end
        end
      end
      S_DONE: begin
        // The handshake only closes once the requester has dropped Enable.
        if (!Enable) begin
          moc_d   = 1'b0;
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      moc_q   <= 1'b0;
      err_q   <= 1'b0;
      dout_q  <= 32'h0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      op_q    <= 6'h0;
      din_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      moc_q   <= moc_d;
      err_q   <= err_d;
      dout_q  <= dout_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      op_q    <= op_d;
      din_q   <= din_d;
    end
  end

  // NOTE: the memory array has no reset; its contents must survive reset and it maps to plain RAM.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      unique case (size)
        SZ_WORD: begin
          Mem[addr_q] <= din_q[31:24];
          Mem[a1]     <= din_q[23:16];
          Mem[a2]     <= din_q[15:8];
          Mem[a3]     <= din_q[7:0];
        end
        SZ_HALF: begin
          Mem[addr_q] <= din_q[15:8];
          Mem[a1]     <= din_q[7:0];
        end
        SZ_BYTE: Mem[addr_q] <= din_q[7:0];
        default: ;
      endcase
    end
  end

  assign DataOut = dout_q;
  assign MOC     = moc_q;
  assign Err     = err_q;

endmodule

// File: tb/tb_ram_moc_responder.sv
// Directed bench for ram_moc_responder: handshake latency, sized reads/writes,
// alignment/illegal-OP errors, abort in WAIT and asynchronous reset in DONE.
module tb_ram_moc_responder;

  localparam logic [5:0] OP_WORD = 6'b001000;
  localparam logic [5:0] OP_HALF = 6'b000010;
  localparam logic [5:0] OP_BYTE = 6'b000001;
  localparam int         LAT     = 4;

  logic        CLK;
  logic        reset;
  logic        Enable;
  logic        ReadWrite;
  logic [8:0]  Address;
  logic [31:0] DataIn;
  logic [5:0]  OP;
  logic [31:0] DataOut;
  logic        MOC;
  logic        Err;

  int errors = 0;
  int checks = 0;
  int lat;

  ram_moc_responder #(.DEPTH(512), .ADDR_W(9), .WAIT_STATES(2)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .Enable    (Enable),
    .ReadWrite (ReadWrite),
    .Address   (Address),
    .DataIn    (DataIn),
    .OP        (OP),
    .DataOut   (DataOut),
    .MOC       (MOC),
    .Err       (Err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Raises Enable at a negedge, scrambles the bus after capture, and counts
  // edges until MOC rises (bounded at 20).
  task automatic request(input logic rw, input logic [8:0] a, input logic [31:0] d,
                         input logic [5:0] op, output int n);
    Enable = 1'b1; ReadWrite = rw; Address = a; DataIn = d; OP = op;
    @(negedge CLK);
    n = 1;
    Address = ~a; DataIn = ~d; OP = 6'b111111; ReadWrite = ~rw;
    while (!MOC && n < 20) begin
      @(negedge CLK);
      n++;
    end
  endtask

  task automatic release_req(input string tag);
    Enable = 1'b0;
    @(negedge CLK);
    check({tag, " moc_low"}, {31'h0, MOC}, 32'h0);
  endtask

  initial begin
    reset = 1'b0; Enable = 1'b0; ReadWrite = 1'b0; Address = '0; DataIn = '0; OP = '0;
    dut.Mem[0]  = 8'h12; dut.Mem[1]  = 8'h34; dut.Mem[2]  = 8'h56; dut.Mem[3]  = 8'h78;
    dut.Mem[12] = 8'hA0; dut.Mem[13] = 8'hA1; dut.Mem[14] = 8'hA2; dut.Mem[15] = 8'hA3;
    repeat (2) @(negedge CLK);
    check("rst moc",  {31'h0, MOC}, 32'h0);
    check("rst err",  {31'h0, Err}, 32'h0);
    check("rst dout", DataOut,      32'h0);
    reset = 1'b1;
    @(negedge CLK);

    request(1'b1, 9'd0, 32'h0, OP_WORD, lat);
    check("rdw0 latency", lat,          LAT);
    check("rdw0 data",    DataOut,      32'h12345678);
    check("rdw0 err",     {31'h0, Err}, 32'h0);
    release_req("rdw0");
    check("rdw0 dout held", DataOut, 32'h12345678);

    request(1'b1, 9'd2, 32'h0, OP_HALF, lat);
    check("rdh2 latency", lat,     LAT);
    check("rdh2 data",    DataOut, 32'h00005678);
    release_req("rdh2");

    request(1'b1, 9'd3, 32'h0, OP_BYTE, lat);
    check("rdb3 data", DataOut, 32'h00000078);
    release_req("rdb3");

    request(1'b0, 9'd8, 32'hDEADBEEF, OP_WORD, lat);
    check("wrw8 latency",  lat,          LAT);
    check("wrw8 err",      {31'h0, Err}, 32'h0);
    check("wrw8 dout kept", DataOut,     32'h00000078);
    release_req("wrw8");
    check("wrw8 mem11", {24'h0, dut.Mem[11]}, 32'h000000EF);

    request(1'b1, 9'd9, 32'h0, OP_BYTE, lat);
    check("rdb9 data", DataOut, 32'h000000AD);
    release_req("rdb9");

    request(1'b1, 9'd8, 32'h0, OP_WORD, lat);
    check("rdw8 data", DataOut, 32'hDEADBEEF);
    release_req("rdw8");

    request(1'b1, 9'd5, 32'h0, OP_WORD, lat);
    check("rdw5 moc",  {31'h0, MOC}, 32'h1);
    check("rdw5 err",  {31'h0, Err}, 32'h1);
    check("rdw5 dout", DataOut,      32'h0);
    release_req("rdw5");
    check("rdw5 err cleared", {31'h0, Err}, 32'h0);

    request(1'b0, 9'd1, 32'h0000FFFF, OP_HALF, lat);
    check("wrh1 err", {31'h0, Err}, 32'h1);
    release_req("wrh1");
    check("wrh1 mem1", {24'h0, dut.Mem[1]}, 32'h00000034);

    request(1'b1, 9'd0, 32'h0, 6'b000100, lat);
    check("badop err", {31'h0, Err}, 32'h1);
    release_req("badop");

    // Abort a write in WAIT before its completion edge.
    Enable = 1'b1; ReadWrite = 1'b0; Address = 9'd12; DataIn = 32'hCAFEF00D; OP = OP_WORD;
    repeat (2) @(negedge CLK);
    Enable = 1'b0;
    repeat (4) @(negedge CLK);
    check("abort moc",   {31'h0, MOC},          32'h0);
    check("abort mem12", {24'h0, dut.Mem[12]},  32'h000000A0);
    check("abort mem15", {24'h0, dut.Mem[15]},  32'h000000A3);

    request(1'b1, 9'd12, 32'h0, OP_WORD, lat);
    check("rdw12 latency", lat,     LAT);
    check("rdw12 data",    DataOut, 32'hA0A1A2A3);

    // Asynchronous reset while in DONE.
    #2 reset = 1'b0;
    #1;
    check("rst done moc",  {31'h0, MOC}, 32'h0);
    check("rst done dout", DataOut,      32'h0);
    check("rst done mem0", {24'h0, dut.Mem[0]}, 32'h00000012);
    Enable = 1'b0;
    @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);

    request(1'b1, 9'd0, 32'h0, OP_WORD, lat);
    check("post rst latency", lat,     LAT);
    check("post rst data",    DataOut, 32'h12345678);
    release_req("post rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
